// File: rtl/param_serializer.sv
// Parallel-to-serial shifter for UART TX, shadow-captured frame, LSB/MSB order.
// Optional parity output enabled with `define SER_PARITY_EN.
module param_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(DATA_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              data_valid,
  input  logic              ser_en,
`ifdef SER_PARITY_EN
  input  logic              PAR_TYP,
  output logic              par_bit,
`endif
  output logic              ser_data,
  output logic              ser_done,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shadow, shadow_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CNT_W-1:0]  idx;
  logic              sd_nx;
  logic              done_nx;
  logic              load;

  assign idx  = MSB_FIRST ? (LAST - cnt) : cnt;
  assign load = (state == IDLE) && data_valid;
  assign busy = (state == SHIFT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      shadow   <= '0;
      cnt      <= '0;
      ser_data <= 1'b0;
      ser_done <= 1'b0;
    end else begin
      state    <= state_nx;
      shadow   <= shadow_nx;
      cnt      <= cnt_nx;
      ser_data <= sd_nx;
      ser_done <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    cnt_nx    = cnt;
    sd_nx     = ser_data;
    done_nx   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (data_valid) begin
          shadow_nx = P_DATA;
          cnt_nx    = '0;
          state_nx  = SHIFT;
        end
      end
      (state == SHIFT): begin
        if (ser_en) begin
          sd_nx = shadow[idx];
          if (cnt == LAST) begin
            cnt_nx   = '0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit <= 1'b0;
    end else if (load) begin
      par_bit <= (^P_DATA) ^ PAR_TYP;
    end
  end
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: LSB/MSB 8-bit and 7-bit instances,
// one reference model with a bit queue, plus a fixed vector table.
module tb_param_serializer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dv;
  logic        en;
  logic        ptyp;
  logic [31:0] pd;
  logic [2:0]  sd;
  logic [2:0]  dn;
  logic [2:0]  bz;
  logic [2:0]  pb;

  always #5 CLK = ~CLK;

  param_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u0 (
    .CLK(CLK), .RST(RST), .P_DATA(pd[7:0]),
    .data_valid(dv), .ser_en(en),
`ifdef SER_PARITY_EN
    .PAR_TYP(ptyp), .par_bit(pb[0]),
`endif
    .ser_data(sd[0]), .ser_done(dn[0]), .busy(bz[0])
  );

  param_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u1 (
    .CLK(CLK), .RST(RST), .P_DATA(pd[7:0]),
    .data_valid(dv), .ser_en(en),
`ifdef SER_PARITY_EN
    .PAR_TYP(ptyp), .par_bit(pb[1]),
`endif
    .ser_data(sd[1]), .ser_done(dn[1]), .busy(bz[1])
  );

  param_serializer #(.DATA_W(7), .MSB_FIRST(1'b0)) u2 (
    .CLK(CLK), .RST(RST), .P_DATA(pd[6:0]),
    .data_valid(dv), .ser_en(en),
`ifdef SER_PARITY_EN
    .PAR_TYP(ptyp), .par_bit(pb[2]),
`endif
    .ser_data(sd[2]), .ser_done(dn[2]), .busy(bz[2])
  );

`ifndef SER_PARITY_EN
  assign pb = '0;
`endif

  typedef struct {
    logic        dv;
    logic [31:0] pd;
    logic        en;
    logic        sd;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t tbl[10];

  int   n_chk;
  int   n_fail;
  int   active;
  int   nlen;
  logic q[$];
  logic m_busy;
  logic m_sd;
  logic m_done;
  logic m_par;
  int   m_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_busy = 1'b0;
    m_sd   = 1'b0;
    m_done = 1'b0;
    m_par  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic e);
    int w;
    w  = (active == 2) ? 7 : 8;
    dv = v;
    pd = d;
    en = e;
    m_done = 1'b0;
    if (!m_busy) begin
      if (v) begin
        for (int i = 0; i < w; i++) begin
          q.push_back(d[(active == 1) ? (w - 1 - i) : i]);
        end
        m_busy = 1'b1;
        m_cnt  = 0;
        m_par  = (^(d & ((32'd1 << w) - 1))) ^ ptyp;
      end
    end else if (e) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL queue_underflow: got empty expected bit");
      end else begin
        m_sd = q.pop_front();
      end
      m_cnt++;
      if (m_cnt == w) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    chk("ser_data", 32'(sd[active]), 32'(m_sd));
    chk("ser_done", 32'(dn[active]), 32'(m_done));
    chk("busy", 32'(bz[active]), 32'(m_busy));
`ifdef SER_PARITY_EN
    chk("par_bit", 32'(pb[active]), 32'(m_par));
`endif
  endtask

  // Shift with ser_en high until the DUT reports done, bounded.
  task automatic run_frame(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
      if (dn[active]) break;
    end
  endtask

  task automatic do_reset();
    dv  = 1'b0;
    en  = 1'b0;
    RST = 1'b0;
    #2;
    model_clear();
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    active = 0;
    RST    = 1'b0;
    dv     = 1'b0;
    en     = 1'b0;
    ptyp   = 1'b0;
    pd     = '0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ser_data", 32'(sd[k]), 32'd0);
      chk("rst_ser_done", 32'(dn[k]), 32'd0);
      chk("rst_busy", 32'(bz[k]), 32'd0);
      chk("rst_par_bit", 32'(pb[k]), 32'd0);
    end
    RST = 1'b1;

    // 8'hA5 LSB first, ser_en held high including the load cycle
    tbl[0] = '{1'b1, 32'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].dv, tbl[i].pd, tbl[i].en);
      chk($sformatf("tbl%0d_sd", i), 32'(sd[0]), 32'(tbl[i].sd));
      chk($sformatf("tbl%0d_done", i), 32'(dn[0]), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), 32'(bz[0]), 32'(tbl[i].busy));
    end

    // Stall after bit 2 with P_DATA changed mid-frame
    step(1'b1, 32'h3C, 1'b0);
    step(1'b0, 32'h3C, 1'b1);
    step(1'b0, 32'h3C, 1'b1);
    repeat (3) step(1'b0, 32'hFF, 1'b0);
    pd = 32'hFF;
    run_frame(nlen);
    chk("stall_tail_len", 32'(nlen), 32'd6);

    // Load during shift and during the final shift are dropped;
    // load in the ser_done cycle is taken.
    step(1'b1, 32'hAA, 1'b0);
    step(1'b0, 32'h00, 1'b1);
    step(1'b1, 32'h55, 1'b1);
    repeat (5) step(1'b0, 32'h00, 1'b1);
    step(1'b1, 32'h55, 1'b1);
    chk("final_shift_done", 32'(dn[0]), 32'd1);
    step(1'b1, 32'h81, 1'b1);
    chk("b2b_busy", 32'(bz[0]), 32'd1);
    run_frame(nlen);
    chk("b2b_len", 32'(nlen), 32'd8);

    // Asynchronous reset mid-frame
    step(1'b1, 32'hC3, 1'b0);
    repeat (4) step(1'b0, 32'h00, 1'b1);
    chk("pre_rst_busy", 32'(bz[0]), 32'd1);
    en  = 1'b0;
    RST = 1'b0;
    #2;
    chk("async_ser_data", 32'(sd[0]), 32'd0);
    chk("async_ser_done", 32'(dn[0]), 32'd0);
    chk("async_busy", 32'(bz[0]), 32'd0);
    model_clear();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    step(1'b1, 32'h01, 1'b1);
    run_frame(nlen);
    chk("post_rst_len", 32'(nlen), 32'd8);

    // MSB-first instance
    do_reset();
    active = 1;
    step(1'b1, 32'hA5, 1'b0);
    run_frame(nlen);
    chk("msb_a5_len", 32'(nlen), 32'd8);
    step(1'b1, 32'h0F, 1'b0);
    run_frame(nlen);
    chk("msb_0f_len", 32'(nlen), 32'd8);
    chk("msb_0f_last", 32'(sd[1]), 32'd1);

    // 7-bit instance, parity even then odd
    do_reset();
    active = 2;
    ptyp   = 1'b0;
    step(1'b1, 32'h45, 1'b0);
`ifdef SER_PARITY_EN
    chk("par_even_45", 32'(pb[2]), 32'd1);
`endif
    run_frame(nlen);
    chk("w7_len_a", 32'(nlen), 32'd7);
    ptyp = 1'b1;
    step(1'b1, 32'h45, 1'b0);
`ifdef SER_PARITY_EN
    chk("par_odd_45", 32'(pb[2]), 32'd0);
`endif
    ptyp = 1'b0;
    run_frame(nlen);
    chk("w7_len_b", 32'(nlen), 32'd7);
    step(1'b0, 32'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
